// File: rtl/meter_bcd_src.sv
// Taxi-meter trip source: BCD distance/fee accounting plus display scan timing.
// Optional night tariff (doubled per-pulse rate) enabled by defining METER_NIGHT_EN.
module meter_bcd_src #(
  parameter logic [15:0] BASE_FEE   = 16'h0100,
  parameter logic [15:0] BASE_DIST  = 16'h0030,
  parameter logic [3:0]  RATE       = 4'h2,
  parameter int          SCAN_DIV   = 50000,
  parameter int          SWAP_SCANS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        wheel_pulse,
  input  logic        night,
  output logic [15:0] fee,
  output logic [15:0] distance,
  output logic [1:0]  Bit_Sel,
  output logic        d_m,
  output logic        busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (SWAP_SCANS > 1) ? $clog2(SWAP_SCANS) : 1;
  localparam logic [15:0] BCD_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] fee_q, fee_d;
  logic [15:0] dist_q, dist_d;
  logic        busy_q, busy_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]  bit_sel_q, bit_sel_d;
  logic        d_m_q, d_m_d;

  logic [4:0]  inc_amt;
  logic [15:0] dist_inc;
  logic [15:0] fee_inc;

  // Adds a small binary amount (0..18) digit by digit; overflow clamps to 9999.
  function automatic logic [15:0] bcd_add(
    input logic [15:0] v,
    input logic [4:0]  amt
  );
    logic [15:0] r;
    logic [5:0]  s;
    logic [5:0]  c;
    r = '0;
    c = {1'b0, amt};
    for (int i = 0; i < 4; i++) begin
      s = {2'b00, v[i*4 +: 4]} + c;
      if (s >= 6'd20) begin
        r[i*4 +: 4] = 4'(s - 6'd20);
        c = 6'd2;
      end else if (s >= 6'd10) begin
        r[i*4 +: 4] = 4'(s - 6'd10);
        c = 6'd1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c = 6'd0;
      end
    end
    if (c != 6'd0) r = BCD_MAX;
    return r;
  endfunction

`ifdef METER_NIGHT_EN
  assign inc_amt = night ? {RATE, 1'b0} : {1'b0, RATE};
`else
  logic unused_night;
  assign unused_night = night;
  assign inc_amt = {1'b0, RATE};
`endif

  assign dist_inc = bcd_add(dist_q, 5'd1);
  assign fee_inc  = bcd_add(fee_q, inc_amt);

  always_comb begin
    state_d = state_q;
    fee_d   = fee_q;
    dist_d  = dist_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (start) begin
          state_d = RUN;
          dist_d  = '0;
          fee_d   = BASE_FEE;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (wheel_pulse && dist_q != BCD_MAX) begin
          dist_d = dist_inc;
          if (dist_inc > BASE_DIST) fee_d = fee_inc;
        end
        if (stop) begin
          state_d = HOLD;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        fee_d   = '0;
        dist_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Scan timing is free-running and ignores the trip state.
  always_comb begin
    presc_d   = presc_q + 1'b1;
    bit_sel_d = bit_sel_q;
    scan_d    = scan_q;
    d_m_d     = d_m_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d   = '0;
      bit_sel_d = bit_sel_q + 2'd1;
      if (bit_sel_q == 2'd3) begin
        if (scan_q == SW'(SWAP_SCANS - 1)) begin
          scan_d = '0;
          d_m_d  = ~d_m_q;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fee_q     <= '0;
      dist_q    <= '0;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      scan_q    <= '0;
      bit_sel_q <= '0;
      d_m_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fee_q     <= fee_d;
      dist_q    <= dist_d;
      busy_q    <= busy_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      bit_sel_q <= bit_sel_d;
      d_m_q     <= d_m_d;
    end
  end

  assign fee      = fee_q;
  assign distance = dist_q;
  assign busy     = busy_q;
  assign Bit_Sel  = bit_sel_q;
  assign d_m      = d_m_q;

endmodule
